data_access_unit: RTL
=====================

DATA_ACCESS_UNIT -- requirements
Module: data_access_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 valid_i  in  1  MEM-stage instruction valid.
REQ-004 dcache_read  in  1  control-word load request.
REQ-005 dcache_write  in  1  control-word store request.
REQ-006 funct3  in  3  load_funct3_t / store_funct3_t encoding.
REQ-007 addr  in  32  byte address from ALU.
REQ-008 store_data  in  32  rs2 value.
REQ-009 flush  in  1  squash the current instruction.
REQ-010 dmem_resp  in  1  cache completion pulse.
REQ-011 dmem_rdata  in  32  cache read word, valid with dmem_resp.
REQ-012 dmem_read / dmem_write  out  1 each  registered cache strobes.
REQ-013 dmem_address  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 dmem_wdata  out  32  lane-replicated store data.
REQ-015 dmem_byte_enable  out  4  rv32i_mem_wmask.
REQ-016 stall  out  1  holds the pipeline.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 load_data  out  32  extended load result, valid while done=1.
REQ-019 misaligned  out  1  one-cycle access-fault pulse.

Function
REQ-020 FSM states SHALL be IDLE, WAIT and DONE.
REQ-021 Request = valid_i & (dcache_read | dcache_write) & !flush, evaluated only in IDLE.
REQ-022 Illegal request SHALL be: read and write both set; funct3 not in {000,001,010,100,101} for a load or {000,001,010} for a store; lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0.
REQ-023 Illegal request in IDLE SHALL pulse misaligned next cycle, issue no memory access, hold stall low and remain in IDLE.
REQ-024 Legal request in IDLE SHALL drive stall=1 combinationally, latch address, byte enables, wdata and funct3/addr[1:0], and enter WAIT with dmem_read or dmem_write=1 from the next cycle.
REQ-025 In WAIT, dmem_* SHALL stay stable and stall=1 until dmem_resp=1, ignoring all pipeline inputs except flush.
REQ-026 On dmem_resp in WAIT, strobes SHALL drop next cycle, load_data SHALL be registered and the FSM SHALL enter DONE.
REQ-027 In DONE: done=1, stall=0, inputs ignored, and the next state SHALL be IDLE unconditionally, so the same instruction is never reissued.
REQ-028 Minimum latency: request cycle 0, strobe cycle 1, dmem_resp cycle 1, done cycle 2.
REQ-029 Store byte enables: sb 4'b0001<<addr[1:0]; sh 4'b0011<<addr[1:0]; sw 4'b1111.
REQ-030 Store data: sb replicates byte[7:0] four times; sh replicates half[15:0] twice; sw passes through.
REQ-031 Load data: select byte/half at addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-032 For a store, load_data SHALL be 0 in DONE.
REQ-033 flush in WAIT SHALL NOT abort the transaction; the strobe stays until dmem_resp, then the FSM returns to IDLE without DONE and done stays 0.
REQ-034 flush asserted in the same IDLE cycle as a request SHALL suppress the request.
REQ-035 load_data SHALL hold its last value outside DONE.

Reset
REQ-036 rst SHALL force IDLE and clear dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, done, misaligned and load_data to 0 on the next edge, including mid-WAIT.
REQ-037 stall SHALL be 0 during reset, and a dmem_resp arriving after reset SHALL be ignored.

Verification
REQ-038 lb at addr 0x1003, dmem_rdata=0x80FF_FFFF, resp in cycle 1 -> dmem_address 0x1000, byte_enable 1111 unused for reads, done cycle 2, load_data 0xFFFF_FF80; lbu gives 0x0000_0080.
REQ-039 sh store_data 0x1234_ABCD at addr 0x2002 -> dmem_write=1, byte_enable 1100, dmem_wdata 0xABCD_ABCD, stall held until resp after 5 wait cycles, then done.
REQ-040 lw at addr 0x3001 -> misaligned pulse, no dmem strobe, stall 0; read and write both set gives the same response.
REQ-041 flush asserted during WAIT of lw, resp 3 cycles later -> strobe held until resp, done never asserted, FSM returns to IDLE.
REQ-042 rst asserted mid-WAIT -> dmem_read 0 next cycle, all outputs 0; a late dmem_resp produces no done.
REQ-043 Back-to-back sw then lhu -> second access starts only after DONE; exactly one done pulse per instruction.

Source files
------------

// File: rtl/data_access_unit.sv
// Data access unit: turns a MEM-stage load/store into one data-cache
// transaction and returns the extended load result with a done pulse.
module data_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        dcache_read,
    input  logic        dcache_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        flush,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state_q;
    logic        dmem_read_q, dmem_write_q;
    logic [31:0] dmem_address_q, dmem_wdata_q;
    logic [3:0]  byte_enable_q;
    logic        done_q, misaligned_q;
    logic [31:0] load_data_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        is_store_q;
    logic        flushed_q;

    logic        req;
    logic        illegal;
    logic [3:0]  byte_enable_d;
    logic [31:0] wdata_d;

    // Select the addressed byte/half from the returned word and extend it.
    function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        case (f3)
            3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  result = {24'd0, shifted[7:0]};
            3'b101:  result = {16'd0, shifted[15:0]};
            default: result = word;
        endcase
        extend_load = result;
    endfunction

    assign req = valid_i & (dcache_read | dcache_write) & ~flush;

    // Classify the request: conflicting strobes, unknown width or bad alignment.
    always_comb begin
        illegal = 1'b0;
        if (dcache_read && dcache_write) begin
            illegal = 1'b1;
        end else begin
            case (funct3)
                3'b000:  illegal = 1'b0;
                3'b001:  illegal = addr[0];
                3'b010:  illegal = addr[1] | addr[0];
                3'b100:  illegal = dcache_write;
                3'b101:  illegal = dcache_write | addr[0];
                default: illegal = 1'b1;
            endcase
        end
    end

    // Byte lanes and lane-replicated write data; loads fetch the whole word.
    always_comb begin
        byte_enable_d = 4'b1111;
        wdata_d       = store_data;
        if (dcache_write) begin
            case (funct3[1:0])
                2'b00: begin
                    byte_enable_d = 4'b0001 << addr[1:0];
                    wdata_d       = {4{store_data[7:0]}};
                end
                2'b01: begin
                    byte_enable_d = 4'b0011 << addr[1:0];
                    wdata_d       = {2{store_data[15:0]}};
                end
                default: begin
                    byte_enable_d = 4'b1111;
                    wdata_d       = store_data;
                end
            endcase
        end
    end

    // Control FSM with registered cache strobes and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            dmem_address_q <= 32'd0;
            dmem_wdata_q   <= 32'd0;
            byte_enable_q  <= 4'd0;
            done_q         <= 1'b0;
            misaligned_q   <= 1'b0;
            load_data_q    <= 32'd0;
            funct3_q       <= 3'd0;
            offset_q       <= 2'd0;
            is_store_q     <= 1'b0;
            flushed_q      <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q        <= WAIT;
                            dmem_read_q    <= dcache_read;
                            dmem_write_q   <= dcache_write;
                            dmem_address_q <= {addr[31:2], 2'b00};
                            dmem_wdata_q   <= wdata_d;
                            byte_enable_q  <= byte_enable_d;
                            funct3_q       <= funct3;
                            offset_q       <= addr[1:0];
                            is_store_q     <= dcache_write;
                            flushed_q      <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    // A squashed access still runs to completion so the cache
                    // handshake stays intact; only its result is discarded.
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (dmem_resp) begin
                        dmem_read_q  <= 1'b0;
                        dmem_write_q <= 1'b0;
                        if (flushed_q || flush) begin
                            state_q <= IDLE;
                        end else begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            load_data_q <= is_store_q ? 32'd0
                                         : extend_load(funct3_q, offset_q, dmem_rdata);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall = ~rst & (((state_q == IDLE) & req & ~illegal) | (state_q == WAIT));

    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = dmem_address_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_byte_enable = byte_enable_q;
    assign done             = done_q;
    assign misaligned       = misaligned_q;
    assign load_data        = load_data_q;

endmodule
